vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 154 +++++++++++++++
 tb/tb_vga_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA frame grabber: samples sync/blank/RGB on pixel-enable cycles and streams
// RGB332 pixels to a frame buffer, flagging malformed timing via a sticky error.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              blank_b,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              frame_done,
    output logic              sync_err
);

    localparam logic [10:0]       H_L = 11'(H_ACTIVE);
    localparam logic [10:0]       V_L = 11'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              hs_q, vs_q, blank_q;
    logic [10:0]       pix_cnt, line_cnt, lc_after;
    logic [ADDR_W-1:0] addr_cnt, line_base;
    logic              line_act, frame_err;

    logic hfall, vfall, in_cap, line_end, line_act_any, line_in, pix_in;
    logic short_line, frame_end, frame_ok, pix_smp, pix_wr, pix_drop, set_err, clr;

    // Only the top bits of each colour reach RGB332.
    logic unused_bits;
    assign unused_bits = ^{red[4:0], green[4:0], blue[5:0]};

    always_comb begin
        state_d      = state_q;
        clr          = 1'b0;
        hfall        = pix_en & hs_q & ~h_sync;
        vfall        = pix_en & vs_q & ~v_sync;
        in_cap       = (state_q == CAPTURE);
        line_end     = in_cap & hfall;
        line_act_any = line_act | blank_q;
        line_in      = (line_cnt < V_L);
        pix_in       = (pix_cnt < H_L);
        short_line   = line_end & line_act_any & line_in & pix_in;
        // Line end is folded into the frame-end decision so a simultaneous
        // h/v edge still counts the final line.
        lc_after     = (line_end & line_act_any & line_in) ? line_cnt + 11'd1 : line_cnt;
        frame_end    = in_cap & vfall;
        frame_ok     = frame_end & (lc_after == V_L) & ~frame_err & ~short_line;
        pix_smp      = in_cap & pix_en & blank_b & ~hfall & ~vfall;
        pix_wr       = pix_smp & pix_in & line_in;
        pix_drop     = pix_smp & ~(pix_in & line_in);
        set_err      = short_line | pix_drop | (frame_end & ~frame_ok);

        case (state_q)
            IDLE: begin
                if (pix_en) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vfall && arm) begin
                    state_d = CAPTURE;
                    clr     = 1'b1;
                end
            end
            CAPTURE: begin
                if (vfall) begin
                    clr     = arm;
                    state_d = arm ? CAPTURE : WAIT_FRAME;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            addr_cnt   <= '0;
            line_base  <= '0;
            line_act   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= frame_ok;
            sync_err   <= sync_err | set_err;
            if (pix_en) begin
                hs_q    <= h_sync;
                vs_q    <= v_sync;
                blank_q <= blank_b;
            end
            if (clr) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                addr_cnt  <= '0;
                line_base <= '0;
                line_act  <= 1'b0;
                frame_err <= 1'b0;
                x         <= '0;
                y         <= '0;
            end else if (in_cap && pix_en) begin
                frame_err <= frame_err | set_err;
                if (line_end) begin
                    pix_cnt  <= '0;
                    line_act <= 1'b0;
                    line_cnt <= lc_after;
                    if (line_act_any && line_in) line_base <= line_base + H_A;
                    // A short line skips the unwritten tail so the next line
                    // still starts on its own row.
                    if (short_line) addr_cnt <= line_base + H_A;
                end else begin
                    line_act <= line_act | blank_q;
                end
                if (pix_wr) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr_cnt;
                    wr_data  <= {red[7:5], green[7:5], blue[7:6]};
                    x        <= pix_cnt[9:0];
                    y        <= line_cnt[9:0];
                    addr_cnt <= addr_cnt + 1'b1;
                    pix_cnt  <= pix_cnt + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 16x8 raster: table-driven frame scenarios
// plus hand sequences; writes are checked against a scoreboard queue.
module tb_vga_capture;
    localparam int H = 16;
    localparam int V = 8;
    localparam int AW = 19;

    logic clk = 0, rst_n, pix_en, h_sync, v_sync, blank_b, arm;
    logic [7:0] red, green, blue;
    logic wr_en, frame_done, sync_err;
    logic [AW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] x, y;

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
        .blank_b(blank_b), .red(red), .green(green), .blue(blue), .arm(arm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .x(x), .y(y),
        .frame_done(frame_done), .sync_err(sync_err));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [9:0]    px;
        logic [9:0]    py;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        bit arm_v;
        int short_ln;
        int long_ln;
        bit extra;
        int exp_wr;
        int exp_done;
        int exp_err;
    } case_t;
    case_t cases[6];

    int nchk = 0, nerr = 0, nwr = 0, ndone = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nchk++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] rgb332(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            nwr++;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                chk("x", 32'(x), 32'(mon_e.px));
                chk("y", 32'(y), 32'(mon_e.py));
                chk("addr_range", 32'(wr_addr < AW'(H * V)), 32'd1);
            end
        end
        if (rst_n === 1'b1 && frame_done === 1'b1) ndone++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pix(input logic hs, input logic vs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        h_sync = hs; v_sync = vs; blank_b = bl;
        red = r; green = g; blue = b;
        pix_en = 1;
        @(negedge clk);
        pix_en = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) pix(1, 1, 0, 8'h0, 8'h0, 8'h0);
    endtask

    // merge=1 drops h_sync together with the v_sync fall
    task automatic vblank(input bit arm_v, input bit merge);
        arm = arm_v;
        repeat (3) pix(~merge, 0, 0, 8'h0, 8'h0, 8'h0);
        repeat (4) pix(1, 1, 0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic run_lines(input int first, input int last, input bit cap,
                             input int short_ln, input int long_ln, input bit skip_last_hs);
        for (int l = first; l < last; l++) begin
            int npx;
            npx = H;
            if (l == short_ln) npx = H - 1;
            if (l == long_ln)  npx = H + 10;
            for (int p = 0; p < npx; p++) begin
                logic [7:0] r, g;
                exp_t e;
                r = 8'(p * 17);
                g = 8'(l * 37 + 5);
                if (cap && p < H && l < V) begin
                    e.addr = AW'(l * H + p);
                    e.data = rgb332(r, g, 8'hC0);
                    e.px = 10'(p);
                    e.py = 10'(l);
                    sb.push_back(e);
                end
                pix(1, 1, 1, r, g, 8'hC0);
            end
            repeat (2) pix(1, 1, 0, 8'h0, 8'h0, 8'h0);
            if (!(skip_last_hs && l == last - 1)) begin
                repeat (3) pix(0, 1, 0, 8'h0, 8'h0, 8'h0);
                repeat (2) pix(1, 1, 0, 8'h0, 8'h0, 8'h0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 0; pix_en = 0; h_sync = 1; v_sync = 1; blank_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        sb.delete();
        nwr = 0;
        ndone = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_sync_err"}, 32'(sync_err), 0);
    endtask

    task automatic chk_end(input string tag, input int ew, input int ed, input int ee);
        chk({tag, "_writes"}, 32'(nwr), 32'(ew));
        chk({tag, "_frame_done"}, 32'(ndone), 32'(ed));
        chk({tag, "_sync_err"}, 32'(sync_err), 32'(ee));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        //             arm short long extra writes done err
        cases[0] = '{1, -1, -1, 0, H * V,     1, 0};
        cases[1] = '{1,  5, -1, 0, H * V - 1, 0, 1};
        cases[2] = '{1, -1,  3, 0, H * V,     0, 1};
        cases[3] = '{1, -1, -1, 1, H * V,     0, 1};
        cases[4] = '{1, -1,  2, 1, H * V,     0, 1};
        cases[5] = '{0, -1, -1, 0, 0,         0, 0};

        arm = 0; rst_n = 0; pix_en = 0; h_sync = 1; v_sync = 1; blank_b = 0;
        red = 0; green = 0; blue = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        foreach (cases[i]) begin
            do_reset();
            idle(2);
            vblank(cases[i].arm_v, 0);
            run_lines(0, cases[i].extra ? V + 1 : V, cases[i].arm_v,
                      cases[i].short_ln, cases[i].long_ln, 0);
            vblank(cases[i].arm_v, 0);
            idle(2);
            chk_end($sformatf("case%0d", i), cases[i].exp_wr, cases[i].exp_done, cases[i].exp_err);
        end

        // Write latency: one pixel, strobe exactly one clk after sampling.
        begin
            exp_t e;
            do_reset();
            idle(2);
            vblank(1, 0);
            e.addr = 0; e.data = 8'hE3; e.px = 0; e.py = 0;
            sb.push_back(e);
            h_sync = 1; v_sync = 1; blank_b = 1; red = 8'hE0; green = 8'h00; blue = 8'hFF;
            pix_en = 1;
            chk("lat_pre_wr_en", 32'(wr_en), 0);
            @(posedge clk); #1;
            chk("lat_wr_en", 32'(wr_en), 1);
            chk("lat_wr_data", 32'(wr_data), 32'h E3);
            chk("lat_wr_addr", 32'(wr_addr), 0);
            @(negedge clk);
            pix_en = 0; blank_b = 0;
            @(posedge clk); #1;
            chk("lat_wr_en_drop", 32'(wr_en), 0);
            @(negedge clk);
            chk("lat_sb_empty", 32'(sb.size()), 0);
        end

        // Arm gating: first frame skipped, second captured.
        do_reset();
        idle(2);
        vblank(0, 0);
        run_lines(0, V, 0, -1, -1, 0);
        vblank(1, 0);
        run_lines(0, V, 1, -1, -1, 0);
        vblank(1, 0);
        idle(2);
        chk_end("armgate", H * V, 1, 0);

        // Arm dropped mid-frame: that frame completes, the next is ignored.
        do_reset();
        idle(2);
        vblank(1, 0);
        arm = 0;
        run_lines(0, V, 1, -1, -1, 0);
        vblank(0, 0);
        run_lines(0, V, 0, -1, -1, 0);
        vblank(0, 0);
        idle(2);
        chk_end("armdrop", H * V, 1, 0);

        // Final line's h_sync fall coincides with the v_sync fall.
        do_reset();
        idle(2);
        vblank(1, 0);
        run_lines(0, V, 1, -1, -1, 1);
        vblank(1, 1);
        idle(2);
        chk_end("hvsame", H * V, 1, 0);

        // Reset mid-frame, then a fresh full frame.
        do_reset();
        idle(2);
        vblank(1, 0);
        run_lines(0, 3, 1, -1, -1, 0);
        rst_n = 0; pix_en = 0;
        @(negedge clk);
        chk_zero("midrst");
        rst_n = 1;
        sb.delete();
        nwr = 0;
        ndone = 0;
        run_lines(3, V, 0, -1, -1, 0);
        chk("midrst_no_writes", 32'(nwr), 0);
        vblank(1, 0);
        run_lines(0, V, 1, -1, -1, 0);
        vblank(1, 0);
        idle(2);
        chk_end("midrst_after", H * V, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
